// File: rtl/dbc_pkg.sv
// Shared definitions for the data bus controller: access sizes, register map,
// STATUS bit positions, FSM states and the lane/extension helpers.
package dbc_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    // Register window word offsets (byte offset >> 2)
    localparam logic [1:0] REG_STATUS     = 2'd0;
    localparam logic [1:0] REG_FAULT_ADDR = 2'd1;
    localparam logic [1:0] REG_RAM_SIZE   = 2'd2;
    localparam logic [1:0] REG_RSVD       = 2'd3;
    localparam int unsigned REG_WIN_BYTES = 16;

    localparam int STATUS_MISALIGN = 0;
    localparam int STATUS_UNMAPPED = 1;
    localparam int STATUS_BUSY     = 2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } dbc_state_e;

    function automatic logic [3:0] dbc_byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lo;
            SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] dbc_store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SIZE_BYTE: d = {4{wdata[7:0]}};
            SIZE_HALF: d = {2{wdata[15:0]}};
            default:   d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] dbc_load_extend(input logic [31:0] word, input logic [1:0] size,
                                                    input logic [1:0] lo, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (size)
            SIZE_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
            SIZE_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
            default:   res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dbc_bram.sv
// Single-port RAM, WORDS x 32 with per-byte write enables and a registered
// read port (data valid the cycle after the read is issued).
module dbc_bram #(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [3:0]               i_be,
    input  logic [$clog2(WORDS)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_bus_ctrl.sv
// Single-outstanding load/store controller in front of a byte-enabled RAM with
// a mirror alias window and a small STATUS / FAULT_ADDR / RAM_SIZE register block.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | zero-fill RAM one word per cycle; busy=1, req_ready=0
//   ST_IDLE | req_ready=1, accept one request (RAM write/read issued here)
//   ST_RESP | one-cycle rsp_valid pulse, then back to ST_IDLE
module data_bus_ctrl
    import dbc_pkg::*;
#(
    parameter int unsigned RAM_WORDS      = 1024,
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter logic [31:0] MIRROR_BASE    = 32'h8000_0000,
    parameter logic [31:0] REG_BASE       = 32'hFFFF_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    dbc_state_e r_state;
    dbc_state_e w_state_nxt;

    logic [AW-1:0] r_clr_cnt;
    logic [1:0]    r_status;
    logic [31:0]   r_fault_addr;

    logic          r_rsp_err;
    logic          r_rsp_we;
    logic          r_rsp_reg;
    logic [1:0]    r_rsp_size;
    logic [1:0]    r_rsp_lo;
    logic          r_rsp_uns;
    logic [31:0]   r_reg_rdata;

    logic [31:0]   w_ram_off;
    logic [31:0]   w_mir_off;
    logic [31:0]   w_reg_off;
    logic          w_ram_prim;
    logic          w_ram_mir;
    logic          w_ram_hit;
    logic          w_reg_hit;
    logic [AW-1:0] w_ram_idx;
    logic [1:0]    w_reg_idx;
    logic          w_misaligned;
    logic          w_unmapped;
    logic          w_fault;
    logic          w_accept;
    logic          w_init_wr;
    logic          w_clr_last;
    logic [1:0]    w_status_set;
    logic [1:0]    w_status_clr;
    logic [1:0]    w_status_nxt;
    logic [31:0]   w_reg_rdata;

    logic          w_bram_en;
    logic          w_bram_we;
    logic [3:0]    w_bram_be;
    logic [AW-1:0] w_bram_addr;
    logic [31:0]   w_bram_wdata;
    logic [31:0]   w_bram_rdata;

    // Address decode: unsigned offset compare also rejects addresses below a base
    assign w_ram_off  = req_addr - RAM_BASE;
    assign w_mir_off  = req_addr - MIRROR_BASE;
    assign w_reg_off  = req_addr - REG_BASE;
    assign w_ram_prim = (w_ram_off < RAM_BYTES);
    assign w_ram_mir  = (w_mir_off < RAM_BYTES);
    assign w_ram_hit  = w_ram_prim | w_ram_mir;
    assign w_reg_hit  = (w_reg_off < 32'(REG_WIN_BYTES));
    assign w_ram_idx  = w_ram_prim ? w_ram_off[AW+1:2] : w_mir_off[AW+1:2];
    assign w_reg_idx  = w_reg_off[3:2];

    assign w_misaligned = (req_size == SIZE_ILL)
                        | ((req_size == SIZE_HALF) & req_addr[0])
                        | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00))
                        | (w_reg_hit & (req_size != SIZE_WORD));
    assign w_unmapped   = ~w_ram_hit & ~w_reg_hit;
    assign w_fault      = w_misaligned | w_unmapped;

    assign w_accept   = req_valid & req_ready;
    assign w_init_wr  = (r_state == ST_INIT) & ~rst;
    assign w_clr_last = (r_clr_cnt == AW'(RAM_WORDS - 1));

    // Only one sticky bit per fault: misalignment masks the unmapped flag
    assign w_status_set = {w_accept & w_unmapped & ~w_misaligned, w_accept & w_misaligned};
    assign w_status_clr = (w_accept & ~w_fault & w_reg_hit & req_we & (w_reg_idx == REG_STATUS))
                          ? req_wdata[1:0] : 2'b00;
    assign w_status_nxt = (r_status & ~w_status_clr) | w_status_set;

    always_comb begin
        w_reg_rdata = '0;
        case (w_reg_idx)
            REG_STATUS: begin
                w_reg_rdata[STATUS_MISALIGN] = r_status[0];
                w_reg_rdata[STATUS_UNMAPPED] = r_status[1];
                w_reg_rdata[STATUS_BUSY]     = busy;
            end
            REG_FAULT_ADDR: w_reg_rdata = r_fault_addr;
            REG_RAM_SIZE:   w_reg_rdata = RAM_BYTES;
            REG_RSVD:       w_reg_rdata = '0;
            default:        w_reg_rdata = '0;
        endcase
    end

    always_comb begin
        w_bram_en    = 1'b0;
        w_bram_we    = 1'b0;
        w_bram_be    = 4'b0000;
        w_bram_addr  = w_ram_idx;
        w_bram_wdata = dbc_store_data(req_size, req_wdata);
        if (w_init_wr) begin
            w_bram_en    = 1'b1;
            w_bram_we    = 1'b1;
            w_bram_be    = 4'b1111;
            w_bram_addr  = r_clr_cnt;
            w_bram_wdata = '0;
        end else if (w_accept & w_ram_hit & ~w_fault) begin
            w_bram_en = 1'b1;
            w_bram_we = req_we;
            w_bram_be = dbc_byte_en(req_size, req_addr[1:0]);
        end
    end

    dbc_bram #(
        .WORDS(RAM_WORDS)
    ) u_bram (
        .i_clk   (clk),
        .i_en    (w_bram_en),
        .i_we    (w_bram_we),
        .i_be    (w_bram_be),
        .i_addr  (w_bram_addr),
        .i_wdata (w_bram_wdata),
        .o_rdata (w_bram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Outputs are masked by rst so nothing leaks while reset is held
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_INIT: begin
                busy = 1'b1;
                if (w_clr_last) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = ~rst;
                if (req_valid) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid   = ~rst;
                w_state_nxt = ST_IDLE;
                if (~rst) begin
                    rsp_err = r_rsp_err;
                    if (~r_rsp_err & ~r_rsp_we)
                        rsp_rdata = r_rsp_reg ? r_reg_rdata
                                  : dbc_load_extend(w_bram_rdata, r_rsp_size, r_rsp_lo, r_rsp_uns);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt    <= '0;
            r_status     <= 2'b00;
            r_fault_addr <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_we     <= 1'b0;
            r_rsp_reg    <= 1'b0;
            r_rsp_size   <= 2'b00;
            r_rsp_lo     <= 2'b00;
            r_rsp_uns    <= 1'b0;
            r_reg_rdata  <= '0;
        end else begin
            if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + 1'b1;
            r_status <= w_status_nxt;
            if (w_accept & w_fault & (r_status == 2'b00)) r_fault_addr <= req_addr;
            if (w_accept) begin
                r_rsp_err   <= w_fault;
                r_rsp_we    <= req_we;
                r_rsp_reg   <= w_reg_hit;
                r_rsp_size  <= req_size;
                r_rsp_lo    <= req_addr[1:0];
                r_rsp_uns   <= req_unsigned;
                r_reg_rdata <= w_reg_rdata;
            end
        end
    end

endmodule

// File: doc/data_bus_ctrl.md
DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

Interface
REQ-001 Parameter RAM_WORDS, 1024, RAM depth in 32-bit words (power of two, 16..65536).
REQ-002 Parameter RAM_BASE, 32'h0000_0000, byte base of the primary RAM window.
REQ-003 Parameter MIRROR_BASE, 32'h8000_0000, byte base of the alias window mapping the same RAM.
REQ-004 Parameter REG_BASE, 32'hFFFF_0000, byte base of the controller register window (16 bytes).
REQ-005 Parameter CLEAR_ON_RESET, 1, zero-fill the RAM after reset when 1.
REQ-006 Ports: one clock, clk; reset is synchronous and active-high, rst.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_valid  in  1  request present.
REQ-010 req_ready  out  1  request accepted on clk edge when req_valid && req_ready.
REQ-011 req_we  in  1  1 = store, 0 = load.
REQ-012 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-013 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-014 req_addr  in  32  byte address.
REQ-015 req_wdata  in  32  store data, LSB-aligned.
REQ-016 rsp_valid  out  1  one-cycle response pulse.
REQ-017 rsp_rdata  out  32  load result, 0 on store or error.
REQ-018 rsp_err  out  1  access faulted; qualified by rsp_valid.
REQ-019 busy  out  1  high while RAM clear in progress.

Function
REQ-020 FSM states INIT, IDLE, RESP; INIT entered on reset only when CLEAR_ON_RESET=1, else IDLE.
REQ-021 INIT writes zero to word 0..RAM_WORDS-1, one word per cycle, then IDLE; busy=1 and req_ready=0 throughout INIT.
REQ-022 req_ready=1 only in IDLE; acceptance moves IDLE->RESP; RESP always returns to IDLE next cycle (rsp_valid=1 in RESP only).
REQ-023 Latency: rsp_valid asserted exactly one cycle after acceptance for every request; max throughput one request per two cycles.
REQ-024 RAM hit: addr in [RAM_BASE, RAM_BASE+4*RAM_WORDS) or same span at MIRROR_BASE; word index = addr offset [log2(RAM_WORDS)+1:2].
REQ-025 Register hit: addr in [REG_BASE, REG_BASE+16); otherwise unmapped.
REQ-026 Misaligned: size 01 with addr[0]=1, size 10 with addr[1:0]!=0, any size 11, or register access not word-size.
REQ-027 Fault priority: misaligned over unmapped; faulting request writes nothing, rsp_err=1, rsp_rdata=0.
REQ-028 Store: byte enables from size and addr[1:0]; data replicated into selected lane(s); unselected bytes unchanged; written at acceptance edge.
REQ-029 Load: RAM read issued at acceptance edge; lane selected by addr[1:0]; extended to 32 bits per req_unsigned.
REQ-030 Register 0x0 STATUS: bit0 misaligned sticky, bit1 unmapped sticky, bit2 busy; other bits 0.
REQ-031 STATUS store: write-1-to-clear bits 0..1; bit2 read-only; sticky set and clear in same cycle -> set wins.
REQ-032 Register 0x4 FAULT_ADDR: captures req_addr of first fault while STATUS[1:0]==0; read-only.
REQ-033 Register 0x8 RAM_SIZE: reads RAM_WORDS*4; 0xC reads 0; stores to 0x4..0xC ignored without error.
REQ-034 A load of the same word stored by the previous request returns the new data.

Reset
REQ-035 During rst: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, STATUS=0, FAULT_ADDR=0, clear counter=0.
REQ-036 rst asserted mid-INIT or mid-RESP aborts; pending response discarded; INIT restarts from word 0.
REQ-037 RAM contents not reset except via INIT.

Structure
REQ-038 Shared package dbc_pkg holds size encodings, register offsets, STATUS bit positions, FSM state type.
REQ-039 Sub-module dbc_bram: single-port RAM_WORDS x 32, 4 byte enables, 1-cycle synchronous read.

Verification
REQ-040 Reset with CLEAR_ON_RESET=1, RAM_WORDS=16 -> busy high 16 cycles, req_ready rises cycle 17, all words read 0.
REQ-041 Store word 0x8899AABB @0x10, store byte 0x5A @0x12, load half signed @0x12 -> rsp_rdata 0xFFFF885A, err 0.
REQ-042 Load byte unsigned @0x80000013 after REQ-041 -> 0x00000088 (mirror alias).
REQ-043 Store word @0x6 -> rsp_err=1, RAM unchanged, STATUS=0x1, FAULT_ADDR=0x6; then load @0x40000000 -> err, STATUS=0x3, FAULT_ADDR still 0x6.
REQ-044 Store 0x3 to 0xFFFF0000 -> STATUS reads 0; load 0xFFFF0008 -> RAM_WORDS*4.
REQ-045 Assert rst in RESP after a store -> no rsp_valid, outputs zero next cycle.
